// File: rtl/operand_sequencer_pkg.sv
// operand_sequencer_pkg: shared CPU widths, sequencer states and retire counter width
package operand_sequencer_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RETIRE_W = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    FETCH    = 3'd2,
    DISPATCH = 3'd3,
    WAIT_RES = 3'd4,
    WRITE    = 3'd5
  } state_t;
endpackage

// File: rtl/operand_sequencer.sv
// operand_sequencer: one-in-flight read/dispatch/writeback sequencer between decode, register file and ALU
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_src1,
  input  logic [ADDR_W-1:0]   req_src2,
  input  logic [ADDR_W-1:0]   req_dst,
  input  logic                req_wb,
  output logic [ADDR_W-1:0]   rf_read_address1,
  output logic [ADDR_W-1:0]   rf_read_address2,
  input  logic [DATA_W-1:0]   rf_read_data1,
  input  logic [DATA_W-1:0]   rf_read_data2,
  output logic [ADDR_W-1:0]   rf_write_address,
  output logic                rf_write_enable,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [ADDR_W-1:0]   op_dst,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [DATA_W-1:0]   res_data,
  output logic [RETIRE_W-1:0] retire_count
);
  state_t state;
  logic   wb;
  assign req_ready       = state == IDLE;
  assign op_valid        = state == DISPATCH;
  assign res_ready       = state == WAIT_RES;
  assign rf_write_enable = state == WRITE;
  always_ff @(posedge clk)
    if (!reset) begin
      state            <= IDLE;
      wb               <= 1'b0;
      rf_read_address1 <= '0;
      rf_read_address2 <= '0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      op_a             <= '0;
      op_b             <= '0;
      op_dst           <= '0;
      retire_count     <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            rf_read_address1 <= req_src1;
            rf_read_address2 <= req_src2;
            op_dst           <= req_dst;
            wb               <= req_wb;
            state            <= ISSUE;
          end
        ISSUE: state <= FETCH;
        FETCH: begin
          op_a  <= rf_read_data1;
          op_b  <= rf_read_data2;
          state <= DISPATCH;
        end
        DISPATCH:
          if (op_ready) begin
            state <= wb ? WAIT_RES : IDLE;
            if (!wb) retire_count <= retire_count + 1'b1;
          end
        WAIT_RES:
          if (res_valid) begin
            rf_write_data    <= res_data;
            rf_write_address <= op_dst;
            state            <= WRITE;
          end
        WRITE: begin
          retire_count <= retire_count + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Multi-cycle initiator for the 16×8 CPU register file, which has registered read data and a synchronous write port. For each instruction request it:
- drives the two read addresses and waits out the file's one-cycle read latency;
- hands the captured operands to the ALU with a valid/ready handshake;
- collects the result and issues the register-file write.

It sits between instruction decode and the register file/ALU, and keeps one instruction in flight.

## Interface
Parameters:
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 8, register/operand width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  decode presents an instruction
- req_ready  out  1  sequencer accepts request (high only in IDLE)
- req_src1, req_src2  in  ADDR_W  source register addresses
- req_dst  in  ADDR_W  destination register address
- req_wb  in  1  1 = result must be written back
- rf_read_address1, rf_read_address2  out  ADDR_W  to register file read ports
- rf_read_data1, rf_read_data2  in  DATA_W  registered read data from file
- rf_write_address  out  ADDR_W  to register file
- rf_write_enable  out  1  one-cycle write strobe
- rf_write_data  out  DATA_W  write value
- op_valid  out  1  operands valid to ALU
- op_ready  in  1  ALU accepts operands
- op_a, op_b  out  DATA_W  operand values
- op_dst  out  ADDR_W  destination, passed through
- res_valid  in  1  ALU result valid
- res_ready  out  1  sequencer accepts result
- res_data  in  DATA_W  ALU result
- retire_count  out  8  completed-instruction counter

## Operation
- FSM states, in order: IDLE, ISSUE, FETCH, DISPATCH, WAIT_RES, WRITE.
- IDLE: req_ready=1. On req_valid, latch src1/src2/dst/wb, then go to ISSUE.
- ISSUE: rf_read_address1/2 driven from the latched srcs. These outputs hold their value in all states except IDLE. Advance unconditionally.
- FETCH: register file data is now visible. At the closing edge, capture it into op_a/op_b. Advance to DISPATCH.
- DISPATCH: op_valid=1, and op_a/op_b/op_dst stay stable until op_ready. On op_ready:
  - wb=1: go to WAIT_RES;
  - wb=0: go to IDLE and increment retire_count.
- WAIT_RES: res_ready=1. On res_valid, latch res_data into rf_write_data, set rf_write_address=dst, then go to WRITE.
- WRITE: rf_write_enable=1 for exactly this cycle. Then go to IDLE and increment retire_count.
- retire_count wraps from 255 to 0.
- No hazard logic is needed, because one instruction is in flight at a time. A write completes at the WRITE→IDLE edge, before the next ISSUE, so a following read of the same register returns the new value.
- Inputs are ignored outside their handshake states: req_* outside IDLE, op_ready outside DISPATCH, res_* outside WAIT_RES.
- src1 == src2 is legal; op_a == op_b.
- Writing to register 0 is an ordinary write; register 0 is not hardwired.

## Timing
- Reset (reset=0 at a rising edge):
  - state goes to IDLE and all outputs clear to 0, including retire_count, op_*, rf_write_* and read addresses;
  - req_ready is 1 in the first cycle after reset.
- Reset mid-operation abandons the instruction. A pending writeback is dropped and no rf_write_enable pulse is issued.
- Latency from request accept at edge E0:
  - ISSUE during E0–E1;
  - FETCH during E1–E2;
  - op_valid high from E2.
- Minimum cycles per instruction, from accept to next req_ready:
  - wb=0: 4 cycles (op_ready=1 on the first DISPATCH cycle);
  - wb=1: 6 cycles (res_valid already high on entering WAIT_RES).
- op_valid and res_ready are registered state decodes, with no combinational path from op_ready/res_valid.
- rf_write_enable is a registered output, high exactly one cycle per writeback.

## Structure
- Shared CPU package holds:
  - ADDR_W/DATA_W defaults;
  - the state enumeration (3-bit encoding: IDLE=0 … WRITE=5);
  - the retire counter width constant.
- Single flat module; no sub-module needed. The register file is instantiated beside it at the top level, not inside it.

## Test plan
- Preload the file with R3=0x12 and R5=0x34. Request src1=3, src2=5, dst=7, wb=1. ALU returns 0x46 → op_a=0x12 and op_b=0x34 appear 2 cycles after accept; R7=0x46 after the WRITE pulse; retire_count=1.
- Hold op_ready=0 for 5 cycles in DISPATCH → op_valid stays high with operands stable; no second request is accepted (req_ready=0).
- Request with wb=0 → no rf_write_enable pulse; IDLE is reached 4 cycles after accept with op_ready tied high.
- Back-to-back requests: write R2=0x55, then read src1=2 → op_a=0x55, with no stale value.
- Pull reset low while in WAIT_RES → next cycle is IDLE with all outputs 0; no write occurs even if res_valid is high at that edge.
- 256 wb=0 requests → retire_count wraps to 0.
